// File: rtl/div_fixed_pkg.sv
// rtl/div_fixed_pkg.sv - fixed-point format constants and helpers shared by div_fixed
package div_fixed_pkg;

  localparam int FULL_WIDTH = 32;
  localparam int FRAC_WIDTH = 16;
  // Quotient bits produced per division: integer and fraction part of the result
  localparam int QBITS      = FULL_WIDTH + FRAC_WIDTH;

  typedef logic signed [FULL_WIDTH-1:0] fixed;

  localparam fixed FIXED_MAX = {1'b0, {(FULL_WIDTH-1){1'b1}}};
  localparam fixed FIXED_MIN = {1'b1, {(FULL_WIDTH-1){1'b0}}};

  // Magnitude as an unsigned value, so FIXED_MIN maps to 2^(FULL_WIDTH-1) without loss
  function automatic logic [FULL_WIDTH-1:0] fixed_abs(input fixed v);
    return v[FULL_WIDTH-1] ? unsigned'(-v) : unsigned'(v);
  endfunction

endpackage

// File: rtl/div_fixed_if.sv
// rtl/div_fixed_if.sv - operand/result handshake bundle for div_fixed
interface div_fixed_if;
  import div_fixed_pkg::*;

  fixed din_a;
  fixed din_b;
  logic din_valid;
  logic din_ready;
  fixed dout;
  logic dout_valid;
  logic div_by_zero;
  logic overflow;

  modport master (
    output din_a, din_b, din_valid,
    input  din_ready, dout, dout_valid, div_by_zero, overflow
  );

  modport slave (
    input  din_a, din_b, din_valid,
    output din_ready, dout, dout_valid, div_by_zero, overflow
  );

endinterface

// File: rtl/div_fixed_step.sv
// rtl/div_fixed_step.sv - one combinational restoring division step
module div_fixed_step
  import div_fixed_pkg::*;
(
  input  logic [FULL_WIDTH-1:0] rem_in,
  input  logic [FULL_WIDTH-1:0] divisor,
  input  logic                  bit_in,
  output logic [FULL_WIDTH-1:0] rem_out,
  output logic                  q_bit
);

  // Working remainder is one bit wider than the divisor so the shift-in never loses the MSB
  logic [FULL_WIDTH:0] shifted;

  // Shift in the next numerator bit, subtract the divisor when it fits
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? FULL_WIDTH'(shifted - {1'b0, divisor}) : shifted[FULL_WIDTH-1:0];
  end

endmodule

// File: rtl/div_fixed.sv
// rtl/div_fixed.sv - sequential signed fixed-point divider; DIV_FIXED_SAT_EN selects saturation on overflow
module div_fixed
  import div_fixed_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic        clk,
  input logic        rst,
  div_fixed_if.slave bus
);

  localparam int N_STEPS = QBITS / BITS_PER_CYCLE;
  localparam int CNT_W   = $clog2(N_STEPS);

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t                  state;
  logic [QBITS-1:0]        num;
  logic [QBITS-1:0]        quot;
  logic [FULL_WIDTH-1:0]   rem;
  logic [FULL_WIDTH-1:0]   div_mag;
  logic                    res_neg;
  logic                    a_neg;
  logic                    b_zero;
  logic [CNT_W-1:0]        cnt;

  logic [FULL_WIDTH-1:0]   rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  logic [FULL_WIDTH-1:0]   q_lo;
  logic                    q_hi_any;
  logic                    ovf_c;
  fixed                    res_c;

  assign bus.din_ready = (state == IDLE);
  assign rem_chain[0]  = rem;

  // Chain of restoring steps consuming numerator bits MSB first; first step yields the top quotient bit
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_fixed_step u_step (
      .rem_in  (rem_chain[i]),
      .divisor (div_mag),
      .bit_in  (num[QBITS-1-i]),
      .rem_out (rem_chain[i+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
    );
  end

  // Sign application, range check and special-case result selection for the FINAL cycle
  always_comb begin
    q_lo     = quot[FULL_WIDTH-1:0];
    q_hi_any = |quot[QBITS-1:FULL_WIDTH];
    if (res_neg) begin
      ovf_c = q_hi_any | (q_lo[FULL_WIDTH-1] & (|q_lo[FULL_WIDTH-2:0]));
    end else begin
      ovf_c = q_hi_any | q_lo[FULL_WIDTH-1];
    end
    // Negating a zero magnitude gives zero, so -0 never appears
    res_c = res_neg ? fixed'(-q_lo) : fixed'(q_lo);
`ifdef DIV_FIXED_SAT_EN
    if (ovf_c) begin
      res_c = res_neg ? FIXED_MIN : FIXED_MAX;
    end
`endif
    if (b_zero) begin
      res_c = a_neg ? FIXED_MIN : FIXED_MAX;
      ovf_c = 1'b0;
    end
  end

  // Control FSM with datapath registers and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      num             <= '0;
      quot            <= '0;
      rem             <= '0;
      div_mag         <= '0;
      res_neg         <= 1'b0;
      a_neg           <= 1'b0;
      b_zero          <= 1'b0;
      cnt             <= '0;
      bus.dout        <= '0;
      bus.dout_valid  <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            num     <= {fixed_abs(bus.din_a), {FRAC_WIDTH{1'b0}}};
            div_mag <= fixed_abs(bus.din_b);
            a_neg   <= bus.din_a[FULL_WIDTH-1];
            res_neg <= bus.din_a[FULL_WIDTH-1] ^ bus.din_b[FULL_WIDTH-1];
            b_zero  <= (bus.din_b == '0);
            rem     <= '0;
            quot    <= '0;
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          rem  <= rem_chain[BITS_PER_CYCLE];
          num  <= num << BITS_PER_CYCLE;
          quot <= {quot[QBITS-BITS_PER_CYCLE-1:0], q_bits};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(N_STEPS - 1)) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          bus.dout        <= res_c;
          bus.div_by_zero <= b_zero;
          bus.overflow    <= ovf_c;
          bus.dout_valid  <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
